conditional_pipe: RTL and testbench
===================================

Name: conditional_pipe

Overview:
- Parametrised successor of the Versat conditional select functional unit.
- Selects between two data inputs per cycle using a configurable condition on in0: nonzero, equal, signed-less or signed-greater against a threshold.
- Adds a configurable output pipeline depth, a sample-and-hold mode, a start-delay window and a saturating match counter.
- Sits in the Versat datapath as a unit with `running`/`run` control and configuration ports.

Parameters:
- DATA_W, 32: data width of in0/in1/in2/threshold/out0.
- DELAY_W, 7: width of the delay configuration and counter.
- PIPE_STAGES, 1: total output latency in cycles; legal values ≥1.
- CNT_W, 16: width of match_count.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- running  input  1  accelerator running; high for the whole run.
- run  input  1  single-cycle pulse at run start.
- in0  input  DATA_W  selector / compare operand.
- in1  input  DATA_W  value when condition true.
- in2  input  DATA_W  value when condition false.
- cond_sel  input  2  condition select. 0: |in0. 1: in0==threshold. 2: $signed(in0)<$signed(threshold). 3: $signed(in0)>$signed(threshold).
- threshold  input  DATA_W  compare constant (config).
- hold  input  1  config. 0: select mode. 1: sample-and-hold mode.
- delay  input  DELAY_W  cycles after run before the unit is active (config).
- out0  output  DATA_W  selected data; latency PIPE_STAGES.
- match_count  output  CNT_W  number of active cycles with cond true.

Behaviour:
- Clocking and reset: one clock (clk). rst is synchronous, active-high, and has priority over everything. On reset, every pipeline register, out0, match_count and the delay counter are 0.
- cond: combinational from in0, threshold and cond_sel, evaluated every cycle.
- active = running && (dcnt == 0) && !run.
- Delay counter (dcnt):
  - On run, dcnt <= delay.
  - Otherwise, when running && dcnt != 0, dcnt decrements.
  - Frozen when running = 0.
  - With delay = 0, the unit is active from the cycle after run.
- Stage 0 register s0, hold = 0:
  - Every cycle, regardless of running, s0 <= cond ? in1 : in2.
  - This matches the legacy unit when PIPE_STAGES = 1 and cond_sel = 0.
- Stage 0 register s0, hold = 1:
  - s0 <= in1 only when active && cond; otherwise s0 keeps its value. in2 is ignored.
  - On run, s0 <= 0, so no stale value from a previous run appears.
- Stages 1..PIPE_STAGES-1: plain shift registers, free-running, no enable.
- out0 is the last stage.
- Latency: an input applied at cycle t appears on out0 after exactly PIPE_STAGES clock edges.
- match_count:
  - On run, cleared to 0. Clear has priority over increment in the same cycle.
  - Increments by 1 when active && cond.
  - Saturates at all-ones and never wraps.
  - Holds value after running falls, until the next run or rst.
- Simultaneous events:
  - run while running (re-arm): reload dcnt, clear match_count; hold mode also clears s0.
  - rst mid-run: everything returns to reset values in the next cycle. The pipeline contents are lost.
- Configuration inputs (cond_sel, threshold, hold, delay) are static during a run. Changing them mid-run is undefined for verification purposes, except cond_sel and threshold, which take effect the same cycle.
- All compares are full DATA_W. Signed modes use two's complement.

Test Plan:
- Legacy select: PIPE_STAGES=1, cond_sel=0, hold=0, in1=0xAAAA, in2=0x5555. Drive in0=3 then in0=0 → out0=0xAAAA, then 0x5555, each one cycle later.
- Latency: PIPE_STAGES=3, cond_sel=1, threshold=7. Drive in0=7 with in1=0x11 at cycle t, then in0=8 with in2=0x22 → out0=0x11 at t+3 and 0x22 at t+4. Reset value 0 until then.
- Signed compare: cond_sel=2, threshold=0. Drive in0=0xFFFFFFFF (-1) → selects in1. Drive in0=1 → selects in2. cond_sel=3 with in0=0x80000000 and threshold=0 → selects in2.
- Hold plus delay: hold=1, cond_sel=0, delay=2, run pulse at cycle 0, running high. Drive in0=1 and in1=0x10,0x20,0x30,0x40 at cycles 1..4 → s0 captures first at cycle 3 (0x30) then 0x40. Dropping in0 to 0 holds 0x40. match_count=2 after cycle 4.
- Saturation / re-arm: CNT_W=4, delay=0, cond always true for 20 active cycles → match_count stops at 15. A run pulse during running → match_count=0 the next cycle, then resumes counting.
- Reset mid-run: assert rst for one cycle during an active hold run → out0, all stages, match_count and dcnt are 0 the next cycle. Later input changes without a run pulse do not update s0 in hold mode.

Source files
------------

// File: rtl/conditional_pipe.sv
// Conditional select unit: picks in1/in2 by a configurable compare on in0,
// with optional sample-and-hold, start delay, output pipeline and match counter.
module conditional_pipe #(
  parameter int DATA_W      = 32,
  parameter int DELAY_W     = 7,
  parameter int PIPE_STAGES = 1,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               running,
  input  logic               run,
  input  logic [DATA_W-1:0]  in0,
  input  logic [DATA_W-1:0]  in1,
  input  logic [DATA_W-1:0]  in2,
  input  logic [1:0]         cond_sel,
  input  logic [DATA_W-1:0]  threshold,
  input  logic               hold,
  input  logic [DELAY_W-1:0] delay,
  output logic [DATA_W-1:0]  out0,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [1:0] COND_NONZERO = 2'd0;
  localparam logic [1:0] COND_EQUAL   = 2'd1;
  localparam logic [1:0] COND_LESS    = 2'd2;
  localparam logic [1:0] COND_GREATER = 2'd3;

  logic               cond;
  logic               active;
  logic               count_full;
  logic [DELAY_W-1:0] dcnt;
  logic [DATA_W-1:0]  s0;

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    cond = 1'b0;
    case (cond_sel)
      COND_NONZERO: cond = |in0;
      COND_EQUAL:   cond = (in0 == threshold);
      COND_LESS:    cond = ($signed(in0) < $signed(threshold));
      COND_GREATER: cond = ($signed(in0) > $signed(threshold));
      default:      cond = 1'b0;
    endcase
  end

  // The run cycle itself is never active, so delay=0 starts on the following cycle.
  assign active     = running && (dcnt == '0) && !run;
  assign count_full = &match_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt <= '0;
    end else if (run) begin
      dcnt <= delay;
    end else if (running && (dcnt != '0)) begin
      dcnt <= dcnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= '0;
    end else if (hold) begin
      if (run) begin
        s0 <= '0;
      end else if (active && cond) begin
        s0 <= in1;
      end
    end else begin
      s0 <= cond ? in1 : in2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match_count <= '0;
    end else if (run) begin
      match_count <= '0;
    end else if (active && cond && !count_full) begin
      match_count <= match_count + 1'b1;
    end
  end

  generate
    if (PIPE_STAGES > 1) begin : g_pipe
      logic [DATA_W-1:0] stage_q [1:PIPE_STAGES-1];

      // NOTE: the stage array is explicitly cleared on reset because the
      // pipeline contents are architecturally visible on out0.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 1; i < PIPE_STAGES; i++) begin
            stage_q[i] <= '0;
          end
        end else begin
          stage_q[1] <= s0;
          for (int i = 2; i < PIPE_STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign out0 = stage_q[PIPE_STAGES-1];
    end else begin : g_direct
      assign out0 = s0;
    end
  endgenerate

endmodule

// File: tb/tb_conditional_pipe.sv
// Self-checking bench for conditional_pipe: directed scenarios plus random
// stimulus against a cycle-level behavioural model, on two parameter sets.
module tb_conditional_pipe;

  logic        clk = 1'b0;
  logic        rst, running, run, hold;
  logic [31:0] in0, in1, in2, threshold;
  logic [1:0]  cond_sel;
  logic [6:0]  delay;
  logic [31:0] out_a, out_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: s0 history as a 3-deep shift list, unbounded match tally.
  int          m_dcnt;
  int          m_cnt;
  logic [31:0] m_hist [3];

  always #5 clk = ~clk;

  conditional_pipe #(.DATA_W(32), .DELAY_W(7), .PIPE_STAGES(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .running(running), .run(run),
    .in0(in0), .in1(in1), .in2(in2), .cond_sel(cond_sel), .threshold(threshold),
    .hold(hold), .delay(delay), .out0(out_a), .match_count(cnt_a)
  );

  conditional_pipe #(.DATA_W(32), .DELAY_W(7), .PIPE_STAGES(3), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .running(running), .run(run),
    .in0(in0), .in1(in1), .in2(in2), .cond_sel(cond_sel), .threshold(threshold),
    .hold(hold), .delay(delay), .out0(out_b), .match_count(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic eval_cond();
    case (cond_sel)
      2'd0:    return in0 != 0;
      2'd1:    return in0 == threshold;
      2'd2:    return $signed(in0) < $signed(threshold);
      default: return $signed(in0) > $signed(threshold);
    endcase
  endfunction

  function automatic logic [31:0] sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  // Applies the unit's rules for one clock edge using the inputs now on the wires.
  task automatic model_edge();
    logic        c, act;
    logic [31:0] ns0;
    if (rst) begin
      m_dcnt = 0;
      m_cnt  = 0;
      m_hist = '{32'h0, 32'h0, 32'h0};
      return;
    end
    c   = eval_cond();
    act = running && (m_dcnt == 0) && !run;
    if (!hold)          ns0 = c ? in1 : in2;
    else if (run)       ns0 = 32'h0;
    else if (act && c)  ns0 = in1;
    else                ns0 = m_hist[0];
    if (run)            m_cnt = 0;
    else if (act && c)  m_cnt++;
    if (run)                        m_dcnt = int'(delay);
    else if (running && m_dcnt != 0) m_dcnt--;
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = ns0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("out0_p1", out_a, m_hist[0]);
    check("out0_p3", out_b, m_hist[2]);
    check("cnt_w16", 32'(cnt_a), sat(m_cnt, 65535));
    check("cnt_w4",  32'(cnt_b), sat(m_cnt, 15));
  endtask

  initial begin
    rst = 1'b1; running = 1'b0; run = 1'b0; hold = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; threshold = '0; cond_sel = 2'd0; delay = '0;
    m_dcnt = 0; m_cnt = 0; m_hist = '{32'h0, 32'h0, 32'h0};
    #2;
    step();
    check("reset_out", out_a, 32'h0);
    check("reset_cnt", 32'(cnt_a), 32'h0);
    rst = 1'b0;

    // Legacy select
    in1 = 32'hAAAA; in2 = 32'h5555; in0 = 32'd3;
    step();
    check("legacy_true", out_a, 32'hAAAA);
    in0 = 32'd0;
    step();
    check("legacy_false", out_a, 32'h5555);

    // Latency of the three-stage instance
    rst = 1'b1; step(); rst = 1'b0;
    cond_sel = 2'd1; threshold = 32'd7;
    in0 = 32'd7; in1 = 32'h11; in2 = 32'h0;
    step();
    check("lat_e1", out_b, 32'h0);
    in0 = 32'd8; in1 = 32'h0; in2 = 32'h22;
    step();
    check("lat_e2", out_b, 32'h0);
    step();
    check("lat_e3", out_b, 32'h11);
    step();
    check("lat_e4", out_b, 32'h22);

    // Signed compares
    cond_sel = 2'd2; threshold = 32'h0; in1 = 32'h1; in2 = 32'h2;
    in0 = 32'hFFFF_FFFF; step(); check("slt_neg", out_a, 32'h1);
    in0 = 32'h1;         step(); check("slt_pos", out_a, 32'h2);
    cond_sel = 2'd3;
    in0 = 32'h8000_0000; step(); check("sgt_min", out_a, 32'h2);

    // Hold plus delay
    hold = 1'b1; cond_sel = 2'd0; delay = 7'd2; in0 = 32'd0;
    running = 1'b1; run = 1'b1;
    step();
    run = 1'b0; in0 = 32'd1;
    for (int i = 1; i <= 4; i++) begin
      in1 = 32'(i * 16);
      step();
      if (i == 3) check("hold_first", out_a, 32'h30);
    end
    check("hold_last", out_a, 32'h40);
    check("hold_cnt", 32'(cnt_a), 32'd2);
    in0 = 32'd0; in1 = 32'h99;
    step();
    check("hold_keep", out_a, 32'h40);
    running = 1'b0;
    step();

    // Saturation and re-arm
    hold = 1'b0; delay = 7'd0; in0 = 32'd5;
    running = 1'b1; run = 1'b1; step(); run = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("sat_w4", 32'(cnt_b), 32'd15);
    check("nosat_w16", 32'(cnt_a), 32'd20);
    run = 1'b1; step(); run = 1'b0;
    check("rearm_clear", 32'(cnt_b), 32'd0);
    step();
    check("rearm_resume", 32'(cnt_b), 32'd1);

    // Reset mid-run in hold mode
    hold = 1'b1; in0 = 32'd1; in1 = 32'h55;
    run = 1'b1; step(); run = 1'b0;
    step(); step();
    rst = 1'b1; running = 1'b0; step(); rst = 1'b0;
    check("rst_out_p1", out_a, 32'h0);
    check("rst_out_p3", out_b, 32'h0);
    check("rst_cnt", 32'(cnt_a), 32'h0);
    in1 = 32'h77; step(); step();
    check("rst_nohold", out_a, 32'h0);

    // Randomised phase
    for (int i = 0; i < 600; i++) begin
      run = 1'b0;
      rst = ($urandom_range(99) == 0);
      if ($urandom_range(19) == 0) begin
        run = 1'b1; running = 1'b1;
        hold = $urandom_range(1);
        delay = 7'($urandom_range(5));
      end else if ($urandom_range(29) == 0) begin
        running = ~running;
      end
      if ($urandom_range(9) == 0) begin
        cond_sel = 2'($urandom_range(3));
        threshold = ($urandom_range(1) != 0) ? $urandom : 32'($urandom_range(4));
      end
      case ($urandom_range(3))
        0:       in0 = 32'h0;
        1:       in0 = threshold;
        2:       in0 = $urandom;
        default: in0 = threshold + 32'($urandom_range(2)) - 32'd1;
      endcase
      in1 = $urandom;
      in2 = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
